// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB bridge, the bus interface and the
// APB memory completer.
//   ADDR_WIDTH      : byte address width of the APB bus
//   DATA_WIDTH      : APB data width
//   apb_slv_state_e : completer transfer state (IDLE / ACCESS)
package apb_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus between the bridge (master) and a completer (slave).
//   pselx, penable, pwrite, paddr, pwdata : driven by the bridge
//   pready, prdata, pslverr               : returned by the completer
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH
);

  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave_ram.sv
// apb_slave_ram: DEPTH x DATA_WIDTH flop array.
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset, clears every word
//   we    : write enable
//   widx  : write word index
//   wdata : write data
//   ridx  : read word index (combinational read port)
//   rdata : read data, zero for an index outside the array
module apb_slave_ram #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH fits in IDX_W+1 bits because DEPTH <= 2^IDX_W.
  localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Word storage: clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we && ({1'b0, widx} < DEPTH_L)) begin
      mem_r[widx[AW-1:0]] <= wdata;
    end
  end

  // Combinational read port, guarded against indices past the array.
  always_comb begin
    rdata = {DATA_WIDTH{1'b0}};
    if ({1'b0, ridx} < DEPTH_L) begin
      rdata = mem_r[ridx[AW-1:0]];
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a flop word memory, with per-transfer
// programmable wait states and error response for bad addresses.
//   pclk       : clock, all logic on posedge
//   preset     : synchronous active-high reset
//   bus        : APB slave port (pselx/penable/pwrite/paddr/pwdata in,
//                pready/prdata/pslverr out)
//   wait_cfg_i : wait states for the transfer, sampled in the setup cycle
module apb_slave_mem #(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int DEPTH      = 32,
  parameter int WAIT_W     = 4
) (
  input  logic               pclk,
  input  logic               preset,
  apb_slave_mem_if.slave     bus,
  input  logic [WAIT_W-1:0]  wait_cfg_i
);

  import apb_pkg::*;

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W:0]        DEPTH_L  = DEPTH[IDX_W:0];
  localparam logic [WAIT_W-1:0]     WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_Z   = {DATA_WIDTH{1'b0}};

  apb_slv_state_e        state_r;
  apb_slv_state_e        state_next_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic                  err_r;
  logic                  write_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic [IDX_W-1:0]      idx_s;
  logic                  err_s;
  logic                  setup_s;
  logic                  wait_zero_s;
  logic                  done_s;
  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

  // Setup-phase decode; only ever consumed by registers, never by outputs.
  assign idx_s       = bus.paddr[ADDR_WIDTH-1:2];
  assign err_s       = (bus.paddr[1:0] != 2'b00) | ({1'b0, idx_s} >= DEPTH_L);
  assign setup_s     = (state_r == IDLE) & bus.pselx & ~bus.penable;
  assign wait_zero_s = (wait_cnt_r == {WAIT_W{1'b0}});

  apb_slave_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (pclk),
    .rst   (preset),
    .we    (mem_we_s),
    .widx  (idx_r),
    .wdata (bus.pwdata),
    .ridx  (idx_s),
    .rdata (mem_rdata_s)
  );

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: setup opens a transfer, completion or abort closes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (!bus.pselx) begin
          state_next_s = IDLE;
        end else if (bus.penable && wait_zero_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Transfer context: captured at setup, wait counter burned down in ACCESS.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      err_r      <= 1'b0;
      write_r    <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      rdata_r    <= DATA_Z;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            wait_cnt_r <= wait_cfg_i;
            err_r      <= err_s;
            write_r    <= bus.pwrite;
            idx_r      <= idx_s;
            // The array is read here, so a write completing on the previous
            // edge is already visible to a back-to-back read.
            if (!err_s && !bus.pwrite) begin
              rdata_r <= mem_rdata_s;
            end
          end
        end
        ACCESS: begin
          if (bus.pselx && bus.penable && !wait_zero_s) begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
          end
        end
        default: begin
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Response decode from registered state qualified by pselx/penable.
  always_comb begin
    done_s      = 1'b0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = DATA_Z;
    mem_we_s    = 1'b0;
    if ((state_r == ACCESS) && wait_zero_s && bus.pselx && bus.penable) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    bus.pready  = done_s;
    bus.pslverr = done_s & err_r;
    mem_we_s    = done_s & write_r & ~err_r;
    if (done_s && !write_r && !err_r) begin
      bus.prdata = rdata_r;
    end else begin
      bus.prdata = DATA_Z;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed bench for apb_slave_mem. A word-array model
// predicts pready/pslverr/prdata for every cycle; literal checks pin the
// transfer latencies and read data of the key scenarios.
module tb_apb_slave_mem;

  localparam int DEPTH = 32;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  wait_cfg;

  apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_slave_mem #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .WAIT_W     (4)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .bus        (bus),
    .wait_cfg_i (wait_cfg)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pready_cyc = 0;
  int pready_cnt = 0;
  bit chk_en = 1'b0;

  logic [31:0] model_mem [DEPTH];
  logic        exp_pready;
  logic        exp_pslverr;
  logic [31:0] exp_prdata;
  logic [31:0] last_rdata;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Per-cycle compare against the model's expectation for this cycle.
  always @(negedge pclk) begin
    cyc++;
    if (chk_en) begin
      check("pready", {31'd0, bus.pready}, {31'd0, exp_pready});
      check("pslverr", {31'd0, bus.pslverr}, {31'd0, exp_pslverr});
      check("prdata", bus.prdata, exp_prdata);
      if (bus.pready === 1'b1) begin
        last_pready_cyc = cyc;
        pready_cnt++;
        if (bus.pwrite === 1'b0) last_rdata = bus.prdata;
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic expect_none();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = 32'h0;
  endtask

  task automatic idle_cycle();
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    expect_none();
    step();
  endtask

  // One APB transfer. abort_at / reset_at pick the access cycle (0-based)
  // where pselx is dropped or preset is raised; -1 disables either.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input int w, input int abort_at, input int reset_at,
                      output int start);
    bit err;
    int idx;
    idx = int'(addr[7:2]);
    err = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wd;
    wait_cfg    = 4'(w);
    expect_none();
    start = cyc + 1;
    step();
    wait_cfg    = 4'hF;  // must be ignored outside the setup cycle
    for (int k = 0; k <= w; k++) begin
      if (k == abort_at) begin
        idle_cycle();
        return;
      end
      bus.penable = 1'b1;
      if (k == reset_at) begin
        preset = 1'b1;
        expect_none();
        step();
        preset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        idle_cycle();
        return;
      end
      if (k == w) begin
        exp_pready  = 1'b1;
        exp_pslverr = err;
        exp_prdata  = (!wr && !err) ? model_mem[idx] : 32'h0;
      end else begin
        expect_none();
      end
      step();
      if (k == w && wr && !err) model_mem[idx] = wd;
    end
  endtask

  initial begin
    int s;
    int snap;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    preset      = 1'b1;
    wait_cfg    = 4'h0;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 8'h00;
    bus.pwdata  = 32'h0;
    last_rdata  = 32'h0;
    expect_none();
    step();
    chk_en = 1'b1;
    step();
    preset = 1'b0;
    idle_cycle();

    // Zero-wait write then read of the same word.
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 0, -1, -1, s);
    check("wr_w0_latency", 32'(last_pready_cyc - s), 32'd1);
    xfer(1'b0, 8'h04, 32'h0, 0, -1, -1, s);
    check("rd_w0_latency", 32'(last_pready_cyc - s), 32'd1);
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    idle_cycle();

    // Three wait states: pready on the 4th access cycle, 5-cycle transfer.
    xfer(1'b0, 8'h10, 32'h0, 3, -1, -1, s);
    check("rd_w3_latency", 32'(last_pready_cyc - s), 32'd4);
    check("rd_w3_data", last_rdata, 32'h0);
    idle_cycle();

    // Error transfers: misaligned and out of range.
    xfer(1'b1, 8'h02, 32'h5555AAAA, 1, -1, -1, s);
    xfer(1'b1, 8'h80, 32'h77777777, 0, -1, -1, s);
    xfer(1'b0, 8'h00, 32'h0, 0, -1, -1, s);
    check("word0_after_err", last_rdata, 32'h0);
    xfer(1'b0, 8'h81, 32'h0, 2, -1, -1, s);
    xfer(1'b0, 8'hFC, 32'h0, 0, -1, -1, s);
    idle_cycle();

    // Back-to-back write then read with no idle cycle in between.
    xfer(1'b1, 8'h0C, 32'h00001234, 0, -1, -1, s);
    xfer(1'b0, 8'h0C, 32'h0, 0, -1, -1, s);
    check("b2b_latency", 32'(last_pready_cyc - s), 32'd1);
    check("b2b_data", last_rdata, 32'h00001234);
    idle_cycle();

    // Reset during the 2nd wait cycle of a write.
    snap = pready_cnt;
    xfer(1'b1, 8'h08, 32'hA5A5A5A5, 3, -1, 1, s);
    check("rst_no_pready", 32'(pready_cnt - snap), 32'd0);
    idle_cycle();
    xfer(1'b0, 8'h08, 32'h0, 0, -1, -1, s);
    check("rst_word2", last_rdata, 32'h0);
    xfer(1'b0, 8'h04, 32'h0, 1, -1, -1, s);
    check("rst_word1", last_rdata, 32'h0);
    idle_cycle();

    // Abort mid-wait, then penable without setup.
    xfer(1'b1, 8'h04, 32'h11111111, 0, -1, -1, s);
    snap = pready_cnt;
    xfer(1'b1, 8'h04, 32'h22222222, 2, 1, -1, s);
    bus.pselx   = 1'b1;
    bus.penable = 1'b1;
    expect_none();
    step();
    bus.pselx   = 1'b0;
    step();
    check("abort_no_pready", 32'(pready_cnt - snap), 32'd0);
    idle_cycle();
    xfer(1'b0, 8'h04, 32'h0, 0, -1, -1, s);
    check("abort_mem_kept", last_rdata, 32'h11111111);
    xfer(1'b1, 8'h7C, 32'hCAFEF00D, 2, -1, -1, s);
    check("post_abort_w2_latency", 32'(last_pready_cyc - s), 32'd3);
    xfer(1'b0, 8'h7C, 32'h0, 1, -1, -1, s);
    check("post_abort_rd", last_rdata, 32'hCAFEF00D);
    idle_cycle();
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer with a flop-based word memory, sitting directly downstream of the APB bridge. It consumes the bridge's `pselx`/`penable`/`pwrite`/`paddr`/`pwdata` and returns `pready`/`prdata`/`pslverr`, replacing the bench-driven `pready`. Wait states are programmable per transfer. Misaligned or out-of-range addresses complete with `pslverr`.

## Interface
- `ADDR_WIDTH`, default `apb_pkg::ADDR_WIDTH` (8): byte address width.
- `DATA_WIDTH`, default `apb_pkg::DATA_WIDTH` (32): data width; must be 32.
- `DEPTH`, default 32: number of words; must be ≤ 2^(ADDR_WIDTH-2).
- `WAIT_W`, default 4: width of the wait-state config.
- `pclk` — input — 1 — clock; all logic on posedge.
- `preset` — input — 1 — reset; synchronous, active-high.
- `pselx` — input — 1 — slave select from bridge.
- `penable` — input — 1 — access-phase strobe.
- `pwrite` — input — 1 — 1 = write, 0 = read.
- `paddr` — input — ADDR_WIDTH — byte address.
- `pwdata` — input — DATA_WIDTH — write data.
- `wait_cfg_i` — input — WAIT_W — wait states to insert; sampled in the setup cycle.
- `pready` — output — 1 — transfer completes this cycle.
- `prdata` — output — DATA_WIDTH — read data; valid only when `pready & ~pwrite`.
- `pslverr` — output — 1 — error; valid only with `pready`.

## Operation
- Word index is `paddr[ADDR_WIDTH-1:2]`.
- Error condition: `paddr[1:0] != 0`, or index ≥ DEPTH. The error is decoded in the setup cycle and registered.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when `pselx & ~penable` is sampled. On that edge:
    - load `wait_cnt <= wait_cfg_i`;
    - latch `err_q`, `write_q`, `idx_q`;
    - for a non-error read, latch `rdata_q <= mem[idx]`.
  - In ACCESS with `pselx & penable`:
    - if `wait_cnt != 0`, decrement `wait_cnt` and stay in ACCESS;
    - if `wait_cnt == 0`, the transfer completes; next state is IDLE.
  - ACCESS with `~pselx` (bridge abort) → IDLE. No write, no `pready`.
  - IDLE with `penable` but no preceding setup → ignored. `pready` stays 0.
- `pready = (state == ACCESS) & (wait_cnt == 0) & pselx & penable`.
- `pslverr = pready & err_q`.
- `prdata = (pready & ~write_q & ~err_q) ? rdata_q : 0`.
- A write commits `mem[idx_q] <= pwdata` on the completing edge, only if `~err_q`. An error write leaves memory unchanged.
- During the transfer the bridge holds `paddr`/`pwrite`/`pwdata` stable. Only the values latched at setup are used; `pwdata` is sampled on the completing edge.
- Reset (any state, including mid-transfer) forces:
  - state IDLE, `wait_cnt` 0, `err_q`/`write_q`/`rdata_q` 0;
  - all memory words 0;
  - outputs `pready` 0, `prdata` 0, `pslverr` 0 in the following cycle.

## Timing
- Minimum transfer is 2 cycles (setup + access) with `wait_cfg_i = 0`. `pready` is high in the first access cycle.
- Transfer length is `2 + wait_cfg_i` cycles. Maximum is 2 + (2^WAIT_W − 1).
- Back-to-back: the cycle after completion may be a new setup. The slave is in IDLE and accepts it, so there is no dead cycle.
- Read-after-write to the same word returns the new data. The write commits on the completing edge; the following setup edge reads the array.
- Outputs are decoded from registered state plus the `pselx`/`penable` qualifiers. There is no combinational path from `paddr` or `pwdata` to outputs.

## Structure
- `apb_pkg` holds `ADDR_WIDTH` and `DATA_WIDTH` (shared with the bridge and the interface) and the state enum `apb_slv_state_e {IDLE, ACCESS}`.
- Sub-module `apb_slave_ram`: DEPTH × DATA_WIDTH flop array with one synchronous write port, one combinational read port, and synchronous reset-to-zero.
- The FSM, wait counter and error decode live in the top.

## Test plan
- Write 0xDEADBEEF to 0x04 with wait 0, then read 0x04 → `pready` in the 2nd cycle of each transfer; read returns 0xDEADBEEF; `pslverr` 0.
- Read 0x10 with `wait_cfg_i = 3` → `pready` low for 3 access cycles and high on the 4th; transfer is 5 cycles; `prdata` is 0 until `pready`.
- Write to 0x02 (misaligned), and write to 0x80 with DEPTH = 32 → each completes with `pready` & `pslverr`; a later read of word 0 returns 0; `prdata` stays 0 on error reads.
- Back-to-back write 0x0C = 0x1234 then read 0x0C with no idle cycle → read returns 0x1234 with no extra cycles.
- Assert `preset` during the 2nd wait cycle of a write to 0x08 = 0xA5A5A5A5 → `pready` never asserted; after release, a read of 0x08 returns 0.
- Drop `pselx` mid-wait on a write (abort), then send `penable` without setup → no `pready`; memory unchanged; the next proper transfer completes normally.
